display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller that sits directly upstream of the 7-segment encoder.
//  Holds a NUM_DIGITS-nibble display word in a double-buffered register and scans one digit
//  per slot. Each slot drives bcd/enable into the encoder and one anode line to the display.
//  Commits new words only at frame boundaries (no tearing), blanks leading zeros, and inserts
//  an anode guard interval against ghosting.
// PARAMETERS
//  NUM_DIGITS    8            digits scanned; >=2
//  CLK_HZ        100_000_000  clk frequency
//  FRAME_HZ      1000         full-frame refresh rate; SLOT = CLK_HZ/(FRAME_HZ*NUM_DIGITS), >= GUARD+2
//  GUARD_CYCLES  4            cycles at slot start with all anodes inactive
//  ANODE_LOW     1            1: anode active-low; 0: active-high
// PORTS
//  clk        in   1              system clock
//  rst        in   1              asynchronous, active-high reset
//  load       in   1              request to display value_in (single-cycle pulse or level)
//  value_in   in   4*NUM_DIGITS   nibble i = digit i; digit 0 = rightmost/LSD
//  digit_mask in   NUM_DIGITS     1 = digit i may light; sampled with value_in on commit
//  lz_blank   in   1              1 = blank leading zeros (live, not buffered)
//  bcd        out  4              nibble for encoder
//  enable     out  1              encoder enable; 0 = blank digit
//  anode      out  NUM_DIGITS     one-hot digit select, polarity per ANODE_LOW
//  digit_idx  out  $clog2(NUM_DIGITS)  index of the digit currently driven
//  load_ack   out  1              1-cycle pulse, cycle after a commit
// BEHAVIOUR
//  Reset (async assert, sync release): slot_cnt=0, idx=0, active word=0, active mask=all-1,
//   pending=0, bcd=0, enable=0, anode=all inactive, digit_idx=0, load_ack=0.
//  Slot timer:
//   - slot_cnt counts 0..SLOT-1; tick = (slot_cnt==SLOT-1).
//   - On tick: idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
//   - frame_end = tick && idx==NUM_DIGITS-1.
//  Load buffering:
//   - load=1 copies value_in/digit_mask into the shadow register and sets pending.
//   - A later load before commit overwrites the shadow; last value wins.
//   - On frame_end with pending, or with load in that same cycle: active <= shadow (or value_in
//     directly if load coincides), pending <= 0, load_ack=1 next cycle.
//   - No commit mid-frame, ever.
//   - Frame_end without pending and without load: no commit, no ack.
//  Output stage, all registered; outputs reflect idx one cycle after it changes:
//   - digit_idx = idx.
//   - bcd = active nibble[idx].
//   - lead_zero(i) = lz_blank && i!=0 && nibbles i..NUM_DIGITS-1 all 0. Digit 0 is never LZ-blanked.
//   - enable = mask[idx] && !lead_zero(idx).
//   - anode: bit idx active only when slot_cnt>=GUARD_CYCLES (as seen the prior cycle); all others inactive.
//   - Disabled digits still drive the anode. The encoder blanks the segments.
//  Invariants:
//   - At most one anode active in any cycle.
//   - anode all-inactive for exactly GUARD_CYCLES cycles per slot.
//  Reset mid-frame: all outputs return to reset values immediately; pending load is discarded.
//  Arithmetic:
//   - slot_cnt width = $clog2(SLOT).
//   - idx wraps by explicit compare (NUM_DIGITS need not be a power of two).
// STRUCTURE
//  Shared package display_pkg:
//   - ANODE_LOW default
//   - function slot_cycles(CLK_HZ, FRAME_HZ, NUM_DIGITS)
//   - typedef for the nibble array
//  One sub-module: scan_timer, a slot counter + index counter emitting tick/frame_end/guard.
//  Top instantiates scan_timer plus the load buffer and output register.
//  The encoder is instantiated by the parent, not here.
// TESTING
//  Bench params: NUM_DIGITS=4, CLK_HZ=800, FRAME_HZ=10 (SLOT=20), GUARD=4, ANODE_LOW=1.
//  1. Reset: rst=1 mid-slot.
//     -> anode=4'b1111, enable=0, bcd=0, load_ack=0 in the same cycle.
//     -> After release, digit_idx 0,1,2,3,0 each held 20 cycles.
//  2. load value_in=16'h1234, mask=4'hF mid-frame.
//     -> No change until frame_end, then load_ack pulse.
//     -> Next frame bcd = 4,3,2,1 for idx 0..3, enable=1.
//  3. Two loads in one frame, 16'hAAAA then 16'h00B7.
//     -> Single load_ack; frame shows 00B7.
//     -> With lz_blank=1: enable=1,1,0,0 for idx 0..3.
//  4. value 16'h0000 with lz_blank=1.
//     -> enable=1 only at idx 0; bcd=0.
//     -> mask=4'b1010 with value 16'h5555, lz_blank=0: enable=0,1,0,1.
//  5. Load on exact frame_end cycle.
//     -> Committed at that boundary, load_ack next cycle, new value shown on idx 0.
//  6. Scoreboard every cycle.
//     -> popcount(active anodes)<=1.
//     -> anode=1111 for cycles 0..3 of each slot.
//     -> The active anode bit equals digit_idx otherwise.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the display scan controller: anode polarity default,
// slot-length helper and the nibble type used to build display words.
package display_pkg;

  localparam bit AnodeLowDefault = 1'b1;

  typedef logic [3:0] nibble_t;

  // Clock cycles spent on each digit so that all digits refresh at frame_hz.
  function automatic int unsigned slot_cycles(input int unsigned clk_hz,
                                              input int unsigned frame_hz,
                                              input int unsigned num_digits);
    return clk_hz / (frame_hz * num_digits);
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot and digit-index counters for the display scan; flags the last cycle of a
// frame and the guard window at the start of every slot.
module scan_timer
  import display_pkg::*;
#(
  parameter int unsigned NumDigits   = 8,
  parameter int unsigned ClkHz       = 100_000_000,
  parameter int unsigned FrameHz     = 1000,
  parameter int unsigned GuardCycles = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  output logic                         frame_end_o,
  output logic                         guard_o,
  output logic [$clog2(NumDigits)-1:0] idx_o
);

  localparam int unsigned Slot = slot_cycles(ClkHz, FrameHz, NumDigits);
  localparam int unsigned CntW = (Slot > 1) ? $clog2(Slot) : 1;
  localparam int unsigned IdxW = $clog2(NumDigits);

  localparam logic [CntW-1:0] SlotLast = CntW'(Slot - 1);
  localparam logic [CntW-1:0] GuardCnt = CntW'(GuardCycles);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDigits - 1);

  logic [CntW-1:0] slot_cnt_q, slot_cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            tick;

  assign tick = (slot_cnt_q == SlotLast);

  always_comb begin
    slot_cnt_d = tick ? '0 : slot_cnt_q + CntW'(1);
    idx_d      = idx_q;
    // Explicit wrap so non-power-of-two digit counts work.
    if (tick) begin
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
    end
  end

  assign frame_end_o = tick && (idx_q == IdxLast);
  assign guard_o     = (slot_cnt_q < GuardCnt);
  assign idx_o       = idx_q;

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: double-buffered display word committed
// only at frame boundaries, leading-zero blanking and an anode guard interval.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned CLK_HZ       = 100_000_000,
  parameter int unsigned FRAME_HZ     = 1000,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter bit          ANODE_LOW    = AnodeLowDefault
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       value_in,
  input  logic [NUM_DIGITS-1:0]         digit_mask,
  input  logic                          lz_blank,
  output logic [3:0]                    bcd,
  output logic                          enable,
  output logic [NUM_DIGITS-1:0]         anode,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          load_ack
);

  localparam int unsigned IdxW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AnodeOff = ANODE_LOW ? '1 : '0;

  logic            frame_end;
  logic            in_guard;
  logic [IdxW-1:0] idx;

  scan_timer #(
    .NumDigits  (NUM_DIGITS),
    .ClkHz      (CLK_HZ),
    .FrameHz    (FRAME_HZ),
    .GuardCycles(GUARD_CYCLES)
  ) u_scan_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .frame_end_o(frame_end),
    .guard_o    (in_guard),
    .idx_o      (idx)
  );

  // Load buffer: shadow collects requests, active is what gets scanned.
  nibble_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
  nibble_t [NUM_DIGITS-1:0] active_q, active_d;
  logic [NUM_DIGITS-1:0]    shadow_mask_q, shadow_mask_d;
  logic [NUM_DIGITS-1:0]    mask_q, mask_d;
  logic                     pending_q, pending_d;
  logic                     commit;

  assign commit = frame_end && (pending_q || load);

  always_comb begin
    shadow_d      = shadow_q;
    shadow_mask_d = shadow_mask_q;
    active_d      = active_q;
    mask_d        = mask_q;
    pending_d     = pending_q;
    if (load) begin
      shadow_d      = value_in;
      shadow_mask_d = digit_mask;
      pending_d     = 1'b1;
    end
    // A load landing on the frame boundary bypasses the shadow.
    if (commit) begin
      active_d  = load ? value_in : shadow_q;
      mask_d    = load ? digit_mask : shadow_mask_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q      <= '0;
      shadow_mask_q <= '1;
      active_q      <= '0;
      mask_q        <= '1;
      pending_q     <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      shadow_mask_q <= shadow_mask_d;
      active_q      <= active_d;
      mask_q        <= mask_d;
      pending_q     <= pending_d;
    end
  end

  // Output stage.
  logic [NUM_DIGITS-1:0] lz_vec;
  logic                  zero_above;
  logic                  lead_zero;
  logic [NUM_DIGITS-1:0] anode_sel;

  logic [3:0]            bcd_q, bcd_d;
  logic                  enable_q, enable_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [IdxW-1:0]       digit_idx_q, digit_idx_d;
  logic                  load_ack_q, load_ack_d;

  always_comb begin
    zero_above = 1'b1;
    lz_vec     = '0;
    // lz_vec[i] is set when nibble i and every nibble above it are zero.
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (active_q[i] == 4'h0);
      lz_vec[i]  = zero_above;
    end
    lead_zero = lz_blank && (idx != '0) && lz_vec[idx];

    anode_sel = '0;
    if (!in_guard) begin
      anode_sel[idx] = 1'b1;
    end

    bcd_d       = active_q[idx];
    enable_d    = mask_q[idx] && !lead_zero;
    anode_d     = ANODE_LOW ? ~anode_sel : anode_sel;
    digit_idx_d = idx;
    load_ack_d  = commit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_q       <= 4'h0;
      enable_q    <= 1'b0;
      anode_q     <= AnodeOff;
      digit_idx_q <= '0;
      load_ack_q  <= 1'b0;
    end else begin
      bcd_q       <= bcd_d;
      enable_q    <= enable_d;
      anode_q     <= anode_d;
      digit_idx_q <= digit_idx_d;
      load_ack_q  <= load_ack_d;
    end
  end

  assign bcd       = bcd_q;
  assign enable    = enable_q;
  assign anode     = anode_q;
  assign digit_idx = digit_idx_q;
  assign load_ack  = load_ack_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: 4 digits, 20-cycle slots, 4-cycle guard, active-low anodes.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  digit_mask = 4'hF;
  logic        lz_blank = 1'b0;
  logic [3:0]  bcd;
  logic        enable;
  logic [3:0]  anode;
  logic [1:0]  digit_idx;
  logic        load_ack;

  // g = cycles since reset release, aligned so outputs show slot g%20 of digit (g/20)%4.
  int g;
  int chk_cnt  = 0;
  int pass_cnt = 0;

  display_scan_ctrl #(
    .NUM_DIGITS  (4),
    .CLK_HZ      (800),
    .FRAME_HZ    (10),
    .GUARD_CYCLES(4),
    .ANODE_LOW   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value_in  (value_in),
    .digit_mask(digit_mask),
    .lz_blank  (lz_blank),
    .bcd       (bcd),
    .enable    (enable),
    .anode     (anode),
    .digit_idx (digit_idx),
    .load_ack  (load_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    g++;
  endtask

  task automatic run_to(input int t);
    while (g < t) step();
  endtask

  function automatic logic [3:0] nib(input logic [15:0] w, input int i);
    return w[4*i +: 4];
  endfunction

  task automatic test_reset();
    logic [1:0] exp_idx;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    g   = -1;
    run_to(40);
    value_in = 16'hFFFF;
    load     = 1'b1;
    step();
    load = 1'b0;
    run_to(45);
    chk_cnt++;
    if (anode !== 4'b1011) $display("FAIL pre_reset_anode: got %b expected %b", anode, 4'b1011);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (anode !== 4'hF) $display("FAIL reset_anode: got %b expected %b", anode, 4'hF);
    else pass_cnt++;
    chk_cnt++;
    if (enable !== 1'b0) $display("FAIL reset_enable: got %b expected 0", enable);
    else pass_cnt++;
    chk_cnt++;
    if (bcd !== 4'h0) $display("FAIL reset_bcd: got %h expected 0", bcd);
    else pass_cnt++;
    chk_cnt++;
    if (load_ack !== 1'b0) $display("FAIL reset_load_ack: got %b expected 0", load_ack);
    else pass_cnt++;
    chk_cnt++;
    if (digit_idx !== 2'd0) $display("FAIL reset_digit_idx: got %0d expected 0", digit_idx);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    g   = -1;
    while (g < 99) begin
      step();
      exp_idx = 2'((g / 20) % 4);
      chk_cnt++;
      if (digit_idx !== exp_idx)
        $display("FAIL scan_idx g=%0d: got %0d expected %0d", g, digit_idx, exp_idx);
      else pass_cnt++;
      if (g == 79) begin
        chk_cnt++;
        if (load_ack !== 1'b0) $display("FAIL discarded_pending_ack: got %b expected 0", load_ack);
        else pass_cnt++;
      end
      if (g == 90) begin
        chk_cnt++;
        if (bcd !== 4'h0) $display("FAIL discarded_pending_bcd: got %h expected 0", bcd);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_load();
    logic [15:0] w;
    int          d;
    w = 16'h1234;
    run_to(110);
    value_in   = w;
    digit_mask = 4'hF;
    load       = 1'b1;
    step();
    load     = 1'b0;
    value_in = 16'hDEAD;
    while (g < 239) begin
      step();
      if (g < 159) begin
        chk_cnt++;
        if (load_ack !== 1'b0) $display("FAIL early_ack g=%0d: got %b expected 0", g, load_ack);
        else pass_cnt++;
      end else if (g <= 160) begin
        chk_cnt++;
        if (load_ack !== (g == 159))
          $display("FAIL ack_pulse g=%0d: got %b expected %b", g, load_ack, g == 159);
        else pass_cnt++;
      end
      if (g == 150) begin
        chk_cnt++;
        if (bcd !== 4'h0) $display("FAIL no_midframe_commit: got %h expected 0", bcd);
        else pass_cnt++;
      end
      if (g >= 160 && g % 20 == 10) begin
        d = (g / 20) % 4;
        chk_cnt++;
        if (bcd !== nib(w, d)) $display("FAIL load_bcd d=%0d: got %h expected %h", d, bcd, nib(w, d));
        else pass_cnt++;
        chk_cnt++;
        if (enable !== 1'b1) $display("FAIL load_enable d=%0d: got %b expected 1", d, enable);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] w;
    logic [3:0]  en_exp;
    int          acks;
    int          d;
    w      = 16'h00B7;
    en_exp = 4'b0011;
    acks   = 0;
    run_to(250);
    value_in = 16'hAAAA;
    load     = 1'b1;
    step();
    load = 1'b0;
    run_to(260);
    value_in = w;
    lz_blank = 1'b1;
    load     = 1'b1;
    step();
    load     = 1'b0;
    value_in = 16'h0;
    while (g < 399) begin
      step();
      if (g <= 320 && load_ack === 1'b1) acks++;
      if (g == 319) begin
        chk_cnt++;
        if (load_ack !== 1'b1) $display("FAIL b2b_ack_at_boundary: got %b expected 1", load_ack);
        else pass_cnt++;
      end
      if (g >= 320 && g % 20 == 10) begin
        d = (g / 20) % 4;
        chk_cnt++;
        if (bcd !== nib(w, d)) $display("FAIL b2b_bcd d=%0d: got %h expected %h", d, bcd, nib(w, d));
        else pass_cnt++;
        chk_cnt++;
        if (enable !== en_exp[d])
          $display("FAIL b2b_lz_enable d=%0d: got %b expected %b", d, enable, en_exp[d]);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (acks != 1) $display("FAIL b2b_single_ack: got %0d acks expected 1", acks);
    else pass_cnt++;
  endtask

  task automatic test_zero_and_mask();
    logic [3:0] m;
    int         d;
    m = 4'b1010;
    run_to(410);
    value_in   = 16'h0000;
    digit_mask = 4'hF;
    lz_blank   = 1'b1;
    load       = 1'b1;
    step();
    load = 1'b0;
    while (g < 559) begin
      step();
      if (g >= 480 && g % 20 == 10) begin
        d = (g / 20) % 4;
        chk_cnt++;
        if (enable !== (d == 0)) $display("FAIL zero_lz_enable d=%0d: got %b expected %b", d, enable, d == 0);
        else pass_cnt++;
        chk_cnt++;
        if (bcd !== 4'h0) $display("FAIL zero_bcd d=%0d: got %h expected 0", d, bcd);
        else pass_cnt++;
      end
    end
    run_to(570);
    value_in   = 16'h5555;
    digit_mask = m;
    lz_blank   = 1'b0;
    load       = 1'b1;
    step();
    load       = 1'b0;
    digit_mask = 4'hF;
    while (g < 719) begin
      step();
      if (g >= 640 && g % 20 == 10) begin
        d = (g / 20) % 4;
        chk_cnt++;
        if (enable !== m[d]) $display("FAIL mask_enable d=%0d: got %b expected %b", d, enable, m[d]);
        else pass_cnt++;
        chk_cnt++;
        if (bcd !== 4'h5) $display("FAIL mask_bcd d=%0d: got %h expected 5", d, bcd);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_frame_end_load();
    run_to(797);
    chk_cnt++;
    if (load_ack !== 1'b0) $display("FAIL fe_pre_ack: got %b expected 0", load_ack);
    else pass_cnt++;
    step();
    value_in   = 16'h9876;
    digit_mask = 4'hF;
    load       = 1'b1;
    step();
    load = 1'b0;
    chk_cnt++;
    if (load_ack !== 1'b1) $display("FAIL fe_ack: got %b expected 1", load_ack);
    else pass_cnt++;
    chk_cnt++;
    if (bcd !== 4'h5 || digit_idx !== 2'd3)
      $display("FAIL fe_no_tear: got bcd=%h idx=%0d expected bcd=5 idx=3", bcd, digit_idx);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (bcd !== 4'h6 || digit_idx !== 2'd0 || enable !== 1'b1)
      $display("FAIL fe_new_value: got bcd=%h idx=%0d en=%b expected bcd=6 idx=0 en=1",
               bcd, digit_idx, enable);
    else pass_cnt++;
    chk_cnt++;
    if (load_ack !== 1'b0) $display("FAIL fe_ack_width: got %b expected 0", load_ack);
    else pass_cnt++;
    run_to(879);
    chk_cnt++;
    if (load_ack !== 1'b0) $display("FAIL idle_frame_ack: got %b expected 0", load_ack);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    logic [1:0] exp_idx;
    logic [3:0] exp_anode;
    int         pos;
    while (g < 1040) begin
      step();
      exp_idx = 2'((g / 20) % 4);
      pos     = g % 20;
      chk_cnt++;
      if ($countones(~anode) > 1) $display("FAIL sb_onehot g=%0d: got anode %b expected <=1 active", g, anode);
      else pass_cnt++;
      exp_anode = (pos < 4) ? 4'hF : ~(4'b0001 << exp_idx);
      chk_cnt++;
      if (anode !== exp_anode) $display("FAIL sb_anode g=%0d: got %b expected %b", g, anode, exp_anode);
      else pass_cnt++;
      if (pos >= 4) begin
        chk_cnt++;
        if (digit_idx !== exp_idx)
          $display("FAIL sb_idx g=%0d: got %0d expected %0d", g, digit_idx, exp_idx);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    g = -1;
    test_reset();
    test_load();
    test_back_to_back();
    test_zero_and_mask();
    test_frame_end_load();
    test_scoreboard();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
